// File: rtl/divider.sv
// Unsigned restoring divider (one quotient bit per cycle, MSB first) with side-band tag; WIDTH cycles latency.
// No backpressure: a start is accepted in IDLE/DONE and ignored while BUSY; results hold until the next start.
module divider #(
  parameter int WIDTH  = 64,
  parameter int SIDE_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [WIDTH-1:0]  divisor,
  input  logic [SIDE_W-1:0] side_in,
  output logic [WIDTH-1:0]  quotient,
  output logic [WIDTH-1:0]  remainder,
  output logic [SIDE_W-1:0] side_out,
  output logic              valid_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   res_rem_q, res_rem_d;
  logic [SIDE_W-1:0]  side_q, side_d;
  logic               vld_q, vld_d;

  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic               ge;
  logic               last;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    res_rem_d = res_rem_q;
    side_d    = side_q;
    vld_d     = vld_q;

    // When the shifted remainder overflows WIDTH bits the true difference still fits,
    // so a WIDTH-bit modular subtract gives the exact result.
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    diff      = rem_shift[WIDTH-1:0] - dvs_q;
    ge        = rem_shift[WIDTH] || (rem_shift[WIDTH-1:0] >= dvs_q);
    rem_step  = ge ? diff : rem_shift[WIDTH-1:0];
    // dvd_q shifts out dividend bits at the top and collects quotient bits at the bottom.
    quo_step  = (dvd_q << 1) | WIDTH'(ge);
    last      = (cnt_q == CNT_W'(WIDTH - 1));

    unique case (state_q)
      IDLE, DONE: begin
        if (valid_in) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          cnt_d   = '0;
          side_d  = side_in;
          vld_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        dvd_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          quo_d     = quo_step;
          res_rem_d = rem_step;
          vld_d     = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      res_rem_q <= '0;
      side_q    <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      res_rem_q <= res_rem_d;
      side_q    <= side_d;
      vld_q     <= vld_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = res_rem_q;
  assign side_out  = side_q;
  assign valid_out = vld_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a monitor pops on each valid_out rise.
module tb_divider;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic [9:0]  side_in;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic [9:0]  side_out;
  logic        valid_out;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic [9:0]  s;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic        prev_vld = 1'b0;
  logic [63:0] last_q = '0;
  logic [63:0] last_r = '0;

  divider #(.WIDTH(64), .SIDE_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .dividend  (dividend),
    .divisor   (divisor),
    .side_in   (side_in),
    .quotient  (quotient),
    .remainder (remainder),
    .side_out  (side_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compares each completed result and checks outputs hold in between.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst) begin
      prev_vld = 1'b0;
      last_q   = '0;
      last_r   = '0;
    end else begin
      if (valid_out && !prev_vld) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 64'(valid_out), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("side_out", 64'(side_out), 64'(e.s));
          chk("latency", 64'(cyc), 64'(e.due));
          last_q = e.q;
          last_r = e.r;
        end
      end else begin
        chk("hold_q", quotient, last_q);
        chk("hold_r", remainder, last_r);
      end
      prev_vld = valid_out;
    end
  end

  task automatic start(input logic [63:0] a, input logic [63:0] b, input logic [9:0] s,
                       input logic [63:0] eq, input logic [63:0] er, input bit expect_res);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    side_in  = s;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    if (expect_res) begin
      e.q = eq; e.r = er; e.s = s; e.due = cyc + 64;
      sb.push_back(e);
    end
    chk("vld_drop", 64'(valid_out), 64'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #2;
    chk("done_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic run_one(input logic [63:0] a, input logic [63:0] b, input logic [9:0] s,
                         input logic [63:0] eq, input logic [63:0] er);
    start(a, b, s, eq, er, 1'b1);
    @(negedge clk);
    valid_in = 1'b0;
    wait_done();
  endtask

  initial begin
    rst      = 1'b0;
    valid_in = 1'b0;
    dividend = '0;
    divisor  = '0;
    side_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_q", quotient, 64'd0);
    chk("rst_r", remainder, 64'd0);
    chk("rst_side", 64'(side_out), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 15/3 with cmd 10, tag 3; inputs churn and valid_in stays high while busy.
    start(64'd15, 64'd3, {5'd10, 5'd3}, 64'd5, 64'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dividend = 64'(i * 77 + 1);
      divisor  = 64'(i);
      side_in  = 10'(i + 500);
    end
    @(negedge clk);
    valid_in = 1'b0;
    repeat (20) @(negedge clk);
    valid_in = 1'b1;
    dividend = 64'd999;
    divisor  = 64'd4;
    side_in  = 10'h2AA;
    @(negedge clk);
    valid_in = 1'b0;
    wait_done();

    repeat (2) @(posedge clk);
    #1;
    chk("done_hold", 64'(valid_out), 64'd1);
    run_one(64'd100, 64'd7, 10'h055, 64'd14, 64'd2);

    // Back-to-back from DONE.
    run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 10'h3C1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run_one(64'd7, 64'd9, 10'h007, 64'd0, 64'd7);
    run_one(64'h8000_0000_0000_0000, 64'd1, 10'h100, 64'h8000_0000_0000_0000, 64'd0);
    run_one(64'h1_2345_6789, 64'h1_0000, 10'h0AB, 64'h1_2345, 64'h6789);

    // Abandon a division with reset after about 30 busy cycles.
    start(64'd123, 64'd5, 10'h3FF, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (29) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_out), 64'd0);
    chk("arst_q", quotient, 64'd0);
    chk("arst_r", remainder, 64'd0);
    chk("arst_side", 64'(side_out), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("no_valid_after_rst", 64'(valid_out), 64'd0);

    run_one(64'd20, 64'd4, 10'h014, 64'd5, 64'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter WIDTH, default 64: dividend, divisor, quotient and remainder width.
REQ-002 Parameter SIDE_W, default 10: width of the side-band word carried alongside each division.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port valid_in, input, 1: start request; operands and side_in are sampled when a start is accepted.
REQ-006 Port dividend, input, WIDTH: unsigned dividend.
REQ-007 Port divisor, input, WIDTH: unsigned divisor.
REQ-008 Port side_in, input, SIDE_W: side-band word, for example a command plus tag.
REQ-009 Port quotient, output, WIDTH: unsigned quotient of the last completed division.
REQ-010 Port remainder, output, WIDTH: unsigned remainder of the last completed division.
REQ-011 Port side_out, output, SIDE_W: side_in value captured at the last accepted start.
REQ-012 Port valid_out, output, 1: high while quotient, remainder and side_out hold a completed result.

Function
REQ-013 The block SHALL have states IDLE, BUSY and DONE.
REQ-014 A start SHALL be accepted on a rising edge where valid_in=1 and the state is IDLE or DONE.
REQ-015 In BUSY, valid_in SHALL be ignored; operands and side_out SHALL not change.
REQ-016 On an accepted start, the block SHALL latch dividend and divisor internally, load side_out with side_in, clear valid_out and enter BUSY.
REQ-017 In BUSY, the block SHALL perform restoring shift-subtract division, producing one quotient bit per cycle, MSB first.
REQ-018 The result SHALL be complete after exactly WIDTH cycles in BUSY.
REQ-019 valid_out SHALL rise on the WIDTH-th rising edge after the accepting edge, and the state SHALL become DONE.
REQ-020 In DONE, quotient, remainder, side_out and valid_out=1 SHALL hold until the next accepted start.
REQ-021 A start accepted while in DONE SHALL drop valid_out on that same edge, giving back-to-back operation with no idle cycle.
REQ-022 Arithmetic SHALL be unsigned, with dividend = quotient*divisor + remainder and remainder < divisor.
REQ-023 Divisor 0 SHALL give quotient all ones and remainder = dividend, with the same latency and no error flag.
REQ-024 quotient and remainder SHALL change only on the completion edge, not while partial results are being computed.
REQ-025 Dividend or divisor changes after the accepting edge SHALL NOT affect the running division.

Reset
REQ-026 While rst=0, the block SHALL asynchronously enter IDLE with valid_out=0 and quotient, remainder, side_out and all internal registers at 0.
REQ-027 A reset asserted mid-division SHALL abandon that division; no valid_out pulse SHALL follow the release of reset.
REQ-028 After rst deasserts, the first rising edge with valid_in=1 SHALL be accepted.

Verification
REQ-029 Reset, then dividend=15, divisor=3, side_in=(cmd 10, tag 3), valid_in held high -> valid_out=1 on the 64th edge after acceptance; quotient=5, remainder=0, side_out=(10,3).
REQ-030 During the REQ-029 run, change dividend, divisor and side_in and pulse valid_in while BUSY -> the result is unaffected.
REQ-031 With a DONE result present, valid_in=1 with 100/7 -> valid_out falls on that edge; 64 cycles later quotient=14, remainder=2.
REQ-032 dividend=0xFFFF_FFFF_FFFF_FFFF, divisor=0 -> quotient=all ones, remainder=0xFFFF_FFFF_FFFF_FFFF, normal latency.
REQ-033 Boundary divides: 7/9 -> quotient 0, remainder 7; 2^63/1 -> quotient 2^63, remainder 0.
REQ-034 Assert rst after 30 BUSY cycles -> all outputs 0 immediately, with no valid_out after release; a new 20/4 start gives quotient 5.
